mesh_term_sink: RTL and testbench

//  Downstream consumer for one terminal of the 4x4 router mesh. Watches the terminal's pndng/data_out,

---
 rtl/mesh_pkg.sv | 28 ++
 rtl/sink_fifo.sv | 59 +++++
 rtl/mesh_term_sink.sv | 91 +++++++++
 tb/tb_mesh_term_sink.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// Shared definitions for mesh terminal sinks:
// packet header layout, sink FSM states, destination match.
package mesh_pkg;

  // Header field positions, counted down from the packet MSB
  localparam int NXT_JUMP_MSB = 0;
  localparam int DST_ROW_MSB  = 8;
  localparam int DST_COL_MSB  = 12;

  localparam logic [7:0] BDCST = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } sink_state_t;

  // dst is {dst_row, dst_col}; broadcast packets are always ours
  function automatic logic dst_match(
    input logic [7:0] dst,
    input logic [3:0] row,
    input logic [3:0] col,
    input logic [7:0] bc
  );
    return (dst == {row, col}) || (dst == bc);
  endfunction

endpackage

// File: rtl/sink_fifo.sv
// Show-ahead FIFO buffering accepted packets for the consumer.
// Flags are derived from the occupancy register.
module sink_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mesh_term_sink.sv
// Consumer for one mesh terminal: paced pop FSM, local buffer,
// receive statistics and misroute detection.
module mesh_term_sink
  import mesh_pkg::*;
#(
  parameter int         pckg_sz    = 40,
  parameter int         fifo_depth = 4,
  parameter int         ROW_ID     = 1,
  parameter int         COL_ID     = 1,
  parameter logic [7:0] bdcst      = BDCST,
  parameter int         CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pndng,
  input  logic [pckg_sz-1:0]            data_out,
  output logic                          pop,
  input  logic                          rd_en,
  output logic [pckg_sz-1:0]            rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(fifo_depth):0]   count,
  output logic [CNT_W-1:0]              rx_count,
  output logic [CNT_W-1:0]              misroute_count,
  output logic                          misroute
);

  sink_state_t state_q;
  sink_state_t state_d;
  logic        wr;
  logic        own;
  logic [7:0]  dst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // GAP gives the mesh a cycle to retire its head before re-sampling pndng
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = (pndng && !full) ? POP : IDLE;
      POP:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pop = (state_q == POP);
  assign wr  = pop;
  assign dst = data_out[pckg_sz-1-DST_ROW_MSB -: 8];
  assign own = dst_match(dst, 4'(ROW_ID), 4'(COL_ID), bdcst);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_count       <= '0;
      misroute_count <= '0;
      misroute       <= 1'b0;
    end else if (wr) begin
      if (rx_count != '1) begin
        rx_count <= rx_count + 1'b1;
      end
      if (!own) begin
        misroute <= 1'b1;
        if (misroute_count != '1) begin
          misroute_count <= misroute_count + 1'b1;
        end
      end
    end
  end

  sink_fifo #(
    .W     (pckg_sz),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr),
    .din   (data_out),
    .pop   (rd_en),
    .dout  (rd_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_mesh_term_sink.sv
// Directed bench for mesh_term_sink: pop pacing, buffering,
// misroute counting, async reset and counter saturation.
module tb_mesh_term_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        pndng;
  logic [39:0] data_out;
  logic        pop;
  logic        rd_en;
  logic [39:0] rd_data;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic [15:0] rx_count;
  logic [15:0] misroute_count;
  logic        misroute;

  logic        s_reset;
  logic        s_pndng;
  logic [39:0] s_data;
  logic        s_pop;
  logic        s_rd_en;
  logic [39:0] s_rd_data;
  logic        s_empty;
  logic        s_full;
  logic [2:0]  s_count;
  logic [1:0]  s_rx;
  logic [1:0]  s_mis;
  logic        s_misroute;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mesh_term_sink dut (
    .clk            (clk),
    .reset          (reset),
    .pndng          (pndng),
    .data_out       (data_out),
    .pop            (pop),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .empty          (empty),
    .full           (full),
    .count          (count),
    .rx_count       (rx_count),
    .misroute_count (misroute_count),
    .misroute       (misroute)
  );

  mesh_term_sink #(.CNT_W(2)) sat (
    .clk            (clk),
    .reset          (s_reset),
    .pndng          (s_pndng),
    .data_out       (s_data),
    .pop            (s_pop),
    .rd_en          (s_rd_en),
    .rd_data        (s_rd_data),
    .empty          (s_empty),
    .full           (s_full),
    .count          (s_count),
    .rx_count       (s_rx),
    .misroute_count (s_mis),
    .misroute       (s_misroute)
  );

  function automatic logic [39:0] mk(
    input logic [3:0] row,
    input logic [3:0] col,
    input int         tag
  );
    return {8'h00, row, col, 24'(tag)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  logic [39:0] pk [0:7];
  logic [39:0] mis_p;
  logic [39:0] bc_p;

  initial begin
    for (int i = 0; i < 8; i++) pk[i] = mk(4'd1, 4'd1, i + 1);
    mis_p    = mk(4'd2, 4'd3, 16'hA0);
    bc_p     = mk(4'hF, 4'hF, 16'hB0);
    reset    = 1'b1;
    pndng    = 1'b0;
    data_out = '0;
    rd_en    = 1'b0;
    s_reset  = 1'b1;
    s_pndng  = 1'b1;
    s_data   = mk(4'd3, 4'd2, 16'hC0);
    s_rd_en  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pop", pop, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rx", rx_count, 0);
    chk("rst_miscnt", misroute_count, 0);
    chk("rst_misroute", misroute, 0);

    // 1: held pndng, pop every third cycle until full
    reset    = 1'b0;
    pndng    = 1'b1;
    data_out = pk[0];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t1_pop_hi%0d", k), pop, 1);
      @(negedge clk);
      chk($sformatf("t1_pop_gap%0d", k), pop, 0);
      chk($sformatf("t1_count%0d", k), count, k + 1);
      data_out = pk[k + 1];
      @(negedge clk);
      chk($sformatf("t1_pop_idle%0d", k), pop, 0);
    end
    chk("t1_full", full, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t1_hold%0d", k), pop, 0);
    end
    chk("t1_head", rd_data, pk[0]);

    // 2: one read frees a slot, next IDLE pops again
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("t2_count", count, 3);
    chk("t2_full", full, 0);
    chk("t2_head", rd_data, pk[1]);
    chk("t2_nopop", pop, 0);
    @(negedge clk);
    chk("t2_pop", pop, 1);
    @(negedge clk);
    pndng = 1'b0;
    chk("t2_refill", count, 4);
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("t2_order%0d", k), rd_data, pk[k]);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    chk("t2_empty", empty, 1);
    chk("t2_rx", rx_count, 5);

    // 3: misrouted then broadcast
    pndng    = 1'b1;
    data_out = mis_p;
    @(negedge clk);
    chk("t3_pop_mis", pop, 1);
    @(negedge clk);
    chk("t3_rx_mis", rx_count, 6);
    chk("t3_miscnt", misroute_count, 1);
    chk("t3_misflag", misroute, 1);
    data_out = bc_p;
    @(negedge clk);
    @(negedge clk);
    chk("t3_pop_bc", pop, 1);
    @(negedge clk);
    chk("t3_rx_bc", rx_count, 7);
    chk("t3_miscnt_bc", misroute_count, 1);
    chk("t3_misflag_bc", misroute, 1);

    // 4: read and write on the same edge
    data_out = pk[5];
    @(negedge clk);
    @(negedge clk);
    chk("t4_pop", pop, 1);
    chk("t4_count_pre", count, 2);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    pndng = 1'b0;
    chk("t4_count_rw", count, 2);
    chk("t4_head_bc", rd_data, bc_p);
    rd_en = 1'b1;
    @(negedge clk);
    chk("t4_head_p5", rd_data, pk[5]);
    @(negedge clk);
    chk("t4_empty", empty, 1);
    @(negedge clk);
    @(negedge clk);
    rd_en = 1'b0;
    chk("t4_underflow", count, 0);
    chk("t4_rd_zero", rd_data, 0);

    // 5: async reset while pop is high
    pndng    = 1'b1;
    data_out = pk[6];
    @(negedge clk);
    chk("t5_pop_a", pop, 1);
    @(negedge clk);
    data_out = pk[7];
    @(negedge clk);
    @(negedge clk);
    chk("t5_pop_b", pop, 1);
    chk("t5_count_pre", count, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_pop", pop, 0);
    chk("t5_count", count, 0);
    chk("t5_rx", rx_count, 0);
    chk("t5_miscnt", misroute_count, 0);
    chk("t5_misflag", misroute, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_hold", count, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_resume_pop", pop, 1);
    @(negedge clk);
    pndng = 1'b0;
    chk("t5_resume_cnt", count, 1);
    chk("t5_resume_rx", rx_count, 1);
    chk("t5_resume_data", rd_data, pk[7]);

    // 6: 2-bit counters saturate instead of wrapping
    s_reset = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 5) chk("t6_rx2", s_rx, 2);
    end
    chk("t6_rx_sat", s_rx, 3);
    chk("t6_mis_sat", s_mis, 3);
    chk("t6_flag", s_misroute, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
